lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
- Load/store bus master between the core's memory stage and a single-port byte-write data RAM slave (stb/we/addr/wdata in; rdata/ack/err out).
- Accepts one load or store at a time from the core.
- Checks alignment, generates byte enables and lane-replicated write data, and issues a single-cycle strobe. It then waits for ack/err with a timeout and returns an aligned, sign- or zero-extended load result.

Parameters:
- DATA_WIDTH, 32, bus and register width (must be 32).
- TIMEOUT_CYCLES, 16, WAIT cycles without ack/err before bus_err_o is reported (≥2).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  1  core request valid
- ready_o  out  1  block idle; request accepted when req_i & ready_o
- store_i  in  1  1 = store, 0 = load
- width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- sext_i  in  1  sign-extend load result
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- rvalid_o  out  1  one-cycle completion pulse (loads and stores)
- rdata_o  out  32  extended load data; 0 for stores and errors
- align_err_o  out  1  valid with rvalid_o: misaligned or illegal width
- bus_err_o  out  1  valid with rvalid_o: err_i or timeout
- stb_o  out  1  bus strobe, exactly one cycle per access
- we_o  out  4  byte write enables; 0000 for loads
- addr_o  out  32  word-aligned address (addr_o[1:0]=00)
- wdata_o  out  32  lane-replicated write data
- rdata_i  in  32  slave read data, valid when ack_i=1
- ack_i  in  1  slave acknowledge
- err_i  in  1  slave error

Behaviour:
- Reset (async, rstn_i=0): state IDLE. ready_o=1. stb_o, we_o, rvalid_o, align_err_o and bus_err_o are 0. addr_o, wdata_o, rdata_o and the timeout counter are 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: ready_o=1. On accept, all request fields are registered.
  - Misaligned or illegal request → RESP with align_err=1. No bus access is made.
  - Otherwise → REQ.
  - Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, or width=11.
- REQ: stb_o=1 for this single cycle. addr_o, we_o and wdata_o are driven from registers.
  - ack_i or err_i seen in REQ → RESP (zero-wait slave).
  - Otherwise → WAIT.
- WAIT: stb_o=0. addr_o, we_o and wdata_o are held stable until the response. The counter increments each cycle.
  - ack_i → RESP.
  - err_i → RESP with bus_err=1. err_i takes priority when asserted together with ack_i.
  - Counter reaches TIMEOUT_CYCLES-1 with no response → RESP with bus_err=1.
- RESP: rvalid_o=1 for one cycle. ready_o=0. Next state IDLE. we_o is cleared.
- Lanes:
  - Byte: we = 0001 << addr[1:0]; wdata_o = {4{wdata_i[7:0]}}.
  - Half: we = 0011 << addr[1:0]; wdata_o = {2{wdata_i[15:0]}}.
  - Word: we = 1111; wdata_o = wdata_i.
- Load extract:
  - rdata_i is captured on ack, then shifted right by 8*addr[1:0].
  - The low 8 or 16 bits are kept; the upper bits are filled with the msb if sext, else 0.
  - Word loads pass through unchanged.
- Latency with a 2-cycle slave (ack two cycles after stb): accept at cycle 0, stb cycle 1, ack cycle 3, rvalid cycle 4. Misaligned: rvalid at cycle 1.
- ack_i/err_i while IDLE or RESP are ignored (stray or late responses).
- req_i while ready_o=0 is ignored; the core must hold it.
- A reset in any state aborts the transaction immediately with no rvalid_o. A store mid-flight may or may not have been written.

Decomposition:
- The shared defines include holds:
  - `DATA_WIDTH`;
  - the width encodings `LSU_BYTE/`LSU_HALF/`LSU_WORD (2'b00/01/10);
  - the FSM state encodings.
- Sub-module lsu_load_extend: combinational shift, mask and sign/zero extension of the captured read word (inputs rdata, addr[1:0], width, sext).
- Lane and we generation stays inline.

Test Plan:
- Store word 0xDEADBEEF to addr 0x100 → stb_o pulse 1 cycle, we_o=1111, addr_o=0x100. rvalid_o 4 cycles after accept, no errors. A readback load returns 0xDEADBEEF.
- Store byte 0xA5 to 0x103, then load byte with sext=1 from 0x103 → we_o=1000, wdata_o=0xA5A5A5A5. Load rdata_o=0xFFFFFFA5; the same load with sext=0 → 0x000000A5.
- Load half from 0x102 over a stored word 0x8001_1234 with sext=1 → 0xFFFF8001. With sext=0 → 0x00008001.
- Word load from 0x101 → no stb_o ever, rvalid_o with align_err_o=1 one cycle after accept, rdata_o=0.
- Slave never acks (ack_i tied 0) → exactly one stb_o pulse, rvalid_o with bus_err_o=1 after TIMEOUT_CYCLES WAIT cycles. ready_o then returns to 1.
- err_i and ack_i asserted together in WAIT → bus_err_o=1. Separately, rstn_i pulsed low during WAIT → all outputs at reset values asynchronously, no rvalid_o, next request behaves normally.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// lsu_bus_master_pkg: shared width, lane-size and FSM state encodings for the LSU bus master.
package lsu_bus_master_pkg;
    localparam int LSU_DATA_WIDTH = 32;
    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: aligns a captured read word to its byte lane and sign/zero extends it.
module lsu_load_extend
    import lsu_bus_master_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_width,
    input  logic        i_sext,
    output logic [31:0] o_data
);
    logic [31:0] w_sh;
    assign w_sh   = i_rdata >> {i_lane, 3'b000};
    assign o_data = (i_width == LSU_BYTE) ? {{24{i_sext & w_sh[7]}}, w_sh[7:0]} :
                    (i_width == LSU_HALF) ? {{16{i_sext & w_sh[15]}}, w_sh[15:0]} : i_rdata;
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store master driving a byte-write RAM slave
// with alignment checks, lane replication, response timeout and load extension.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic                  store_i,
    input  logic [1:0]            width_i,
    input  logic                  sext_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  align_err_o,
    output logic                  bus_err_o,
    output logic                  stb_o,
    output logic [3:0]            we_o,
    output logic [31:0]           addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  ack_i,
    input  logic                  err_i
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]            r_state;
    logic                  r_store;
    logic [1:0]            r_width;
    logic                  r_sext;
    logic [1:0]            r_lane;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            r_we;
    logic [CW-1:0]         r_cnt;
    logic                  r_align_err;
    logic                  r_bus_err;
    logic                  w_misalign;
    logic                  w_timeout;
    logic [3:0]            w_we;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_misalign = (width_i == 2'b11) || (width_i == LSU_HALF && addr_i[0]) ||
                        (width_i == LSU_WORD && addr_i[1:0] != 2'b00);
    assign w_we       = (width_i == LSU_BYTE) ? 4'b0001 << addr_i[1:0] :
                        (width_i == LSU_HALF) ? 4'b0011 << addr_i[1:0] : 4'b1111;
    assign w_wdata    = (width_i == LSU_BYTE) ? {4{wdata_i[7:0]}} :
                        (width_i == LSU_HALF) ? {2{wdata_i[15:0]}} : wdata_i;
    assign w_timeout  = r_cnt == CW'(TIMEOUT_CYCLES - 1);

    lsu_load_extend u_ext (
        .i_rdata (r_rdata),
        .i_lane  (r_lane),
        .i_width (r_width),
        .i_sext  (r_sext),
        .o_data  (w_ext)
    );

    assign ready_o     = r_state == S_IDLE;
    assign stb_o       = r_state == S_REQ;
    assign rvalid_o    = r_state == S_RESP;
    assign align_err_o = rvalid_o & r_align_err;
    assign bus_err_o   = rvalid_o & r_bus_err;
    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign rdata_o     = (rvalid_o && !r_store && !r_align_err && !r_bus_err) ? w_ext : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_width     <= LSU_BYTE;
            r_sext      <= 1'b0;
            r_lane      <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_we        <= 4'b0000;
            r_cnt       <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_i) begin
                    r_store     <= store_i;
                    r_width     <= width_i;
                    r_sext      <= sext_i;
                    r_lane      <= addr_i[1:0];
                    r_addr      <= {addr_i[31:2], 2'b00};
                    r_wdata     <= w_wdata;
                    r_we        <= (store_i && !w_misalign) ? w_we : 4'b0000;
                    r_align_err <= w_misalign;
                    r_bus_err   <= 1'b0;
                    r_state     <= w_misalign ? S_RESP : S_REQ;
                end
                S_REQ: begin
                    r_cnt     <= '0;
                    r_rdata   <= rdata_i;
                    r_bus_err <= err_i;
                    r_state   <= (ack_i || err_i) ? S_RESP : S_WAIT;
                end
                S_WAIT: if (ack_i || err_i || w_timeout) begin
                    // err wins over a simultaneous ack; no response at all is a timeout
                    r_rdata   <= rdata_i;
                    r_bus_err <= err_i || !ack_i;
                    r_state   <= S_RESP;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_we    <= 4'b0000;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
